dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 71 +++++++
 tb/tb_dmem_responder.sv | 113 +++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: big-endian data memory with sub-word access, misaligned-store rejection and sticky error flag.
// Store/error counters are built only when DMEM_STATS_EN is defined; otherwise they read as 0.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] addr_to_mem,
  input  logic        write_enable_to_mem,
  input  logic        byte_to_mem,
  input  logic        half_word_to_mem,
  input  logic        sign_extend_to_mem,
  input  logic [0:31] data_to_mem,
  output logic [0:31] data_from_mem,
  output logic        misalign_err,
  output logic [0:31] write_count,
  output logic [0:31] error_count
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] a, d, word_q, wr_word, rd;
  logic [AW-1:0] idx;
  logic [7:0] byte_q;
  logic [15:0] half_q;
  logic is_byte, is_half, is_word, mis, commit, unused_hi;
  assign a = addr_to_mem;
  assign d = data_to_mem;
  assign idx = a[AW+1:2];
  assign unused_hi = ^a[31:AW+2];
  assign is_byte = byte_to_mem;
  assign is_half = !byte_to_mem && half_word_to_mem;
  assign is_word = !byte_to_mem && !half_word_to_mem;
  assign mis = (is_half && a[0]) || (is_word && a[1:0] != 2'b00);
  assign commit = write_enable_to_mem && !mis && !reset;
  // Internal vectors are little-endian numbered, so byte offset 0 sits at [31:24].
  assign word_q = mem[idx];
  assign byte_q = word_q[{~a[1:0], 3'b000} +: 8];
  assign half_q = word_q[{~a[1], 4'b0000} +: 16];
  always_comb begin
    rd = mis ? 32'd0 :
         is_byte ? {{24{sign_extend_to_mem & byte_q[7]}}, byte_q} :
         is_half ? {{16{sign_extend_to_mem & half_q[15]}}, half_q} : word_q;
    data_from_mem = rd;
  end
  always_comb begin
    wr_word = is_word ? d : word_q;
    if (is_byte) wr_word[{~a[1:0], 3'b000} +: 8] = d[7:0];
    if (is_half) wr_word[{~a[1], 4'b0000} +: 16] = d[15:0];
  end
  always_ff @(posedge clock)
    if (commit) mem[idx] <= wr_word;
  always_ff @(posedge clock or posedge reset)
    if (reset) misalign_err <= 1'b0;
    else if (write_enable_to_mem && mis) misalign_err <= 1'b1;
`ifdef DMEM_STATS_EN
  logic [31:0] wc, ec;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wc <= '0;
      ec <= '0;
    end else begin
      if (commit && wc != '1) wc <= wc + 32'd1;
      if (write_enable_to_mem && mis && ec != '1) ec <= ec + 32'd1;
    end
  assign write_count = wc;
  assign error_count = ec;
`else
  assign write_count = '0;
  assign error_count = '0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven directed vectors for dmem_responder plus a mid-cycle reset sequence.
module tb_dmem_responder;
`ifdef DMEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic we = 1'b0, bt = 1'b0, hw = 1'b0, sx = 1'b0;
  logic [0:31] rdata, wc, ec;
  logic err;
  int errors = 0, checks = 0;

  dmem_responder dut (
    .clock(clock), .reset(reset), .addr_to_mem(addr),
    .write_enable_to_mem(we), .byte_to_mem(bt), .half_word_to_mem(hw),
    .sign_extend_to_mem(sx), .data_to_mem(wdata), .data_from_mem(rdata),
    .misalign_err(err), .write_count(wc), .error_count(ec)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic we, bt, hw, sx;
    logic [31:0] addr, data;
    logic chk;
    logic [31:0] rd;
    logic err;
    logic [31:0] wc, ec;
  } vec_t;
  vec_t v[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic cnt_check(input string tag, input logic e, input logic [31:0] w, input logic [31:0] c);
    check({tag, " misalign_err"}, {31'd0, err}, {31'd0, e});
    check({tag, " write_count"}, wc, STATS ? w : 32'd0);
    check({tag, " error_count"}, ec, STATS ? c : 32'd0);
  endtask

  initial begin
    //          we bt hw sx addr          data          chk rd            err wc  ec
    v.push_back('{1, 0, 0, 0, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0, 1, 0});
    v.push_back('{0, 0, 0, 0, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0, 1, 0});
    v.push_back('{1, 0, 0, 0, 32'h10,   32'h01020304, 1, 32'hDEADBEEF, 0, 2, 0});
    v.push_back('{0, 0, 0, 1, 32'h10,   32'h0,        1, 32'h01020304, 0, 2, 0});
    v.push_back('{1, 0, 0, 0, 32'h40,   32'h80F01234, 0, 32'h0,        0, 3, 0});
    v.push_back('{0, 1, 0, 1, 32'h40,   32'h0,        1, 32'hFFFFFF80, 0, 3, 0});
    v.push_back('{0, 1, 0, 1, 32'h41,   32'h0,        1, 32'hFFFFFFF0, 0, 3, 0});
    v.push_back('{0, 1, 0, 0, 32'h40,   32'h0,        1, 32'h00000080, 0, 3, 0});
    v.push_back('{0, 1, 0, 1, 32'h43,   32'h0,        1, 32'h00000034, 0, 3, 0});
    v.push_back('{0, 0, 1, 1, 32'h42,   32'h0,        1, 32'h00001234, 0, 3, 0});
    v.push_back('{0, 0, 1, 1, 32'h40,   32'h0,        1, 32'hFFFF80F0, 0, 3, 0});
    v.push_back('{0, 0, 1, 0, 32'h40,   32'h0,        1, 32'h000080F0, 0, 3, 0});
    v.push_back('{0, 1, 1, 0, 32'h41,   32'h0,        1, 32'h000000F0, 0, 3, 0});
    v.push_back('{0, 0, 0, 1, 32'h40,   32'h0,        1, 32'h80F01234, 0, 3, 0});
    v.push_back('{0, 0, 1, 1, 32'h41,   32'h0,        1, 32'h00000000, 0, 3, 0});
    v.push_back('{1, 0, 0, 0, 32'h20,   32'h11111111, 0, 32'h0,        0, 4, 0});
    v.push_back('{1, 0, 1, 0, 32'h22,   32'h0000ABCD, 1, 32'h00001111, 0, 5, 0});
    v.push_back('{0, 0, 0, 0, 32'h20,   32'h0,        1, 32'h1111ABCD, 0, 5, 0});
    v.push_back('{1, 1, 0, 0, 32'h21,   32'h000000EE, 1, 32'h00000011, 0, 6, 0});
    v.push_back('{0, 0, 0, 0, 32'h20,   32'h0,        1, 32'h11EEABCD, 0, 6, 0});
    v.push_back('{1, 0, 0, 0, 32'h13,   32'hFFFFFFFF, 1, 32'h00000000, 1, 6, 1});
    v.push_back('{0, 0, 0, 0, 32'h10,   32'h0,        1, 32'h01020304, 1, 6, 1});
    v.push_back('{0, 0, 0, 0, 32'h13,   32'h0,        1, 32'h00000000, 1, 6, 1});
    v.push_back('{1, 0, 1, 0, 32'h23,   32'h00005555, 1, 32'h00000000, 1, 6, 2});
    v.push_back('{0, 0, 0, 0, 32'h20,   32'h0,        1, 32'h11EEABCD, 1, 6, 2});
    v.push_back('{1, 0, 0, 0, 32'h1008, 32'h5A5A5A5A, 0, 32'h0,        1, 7, 2});
    v.push_back('{0, 0, 0, 0, 32'h08,   32'h0,        1, 32'h5A5A5A5A, 1, 7, 2});

    #1 cnt_check("reset", 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clock);
      {we, bt, hw, sx} = {v[i].we, v[i].bt, v[i].hw, v[i].sx};
      addr = v[i].addr;
      wdata = v[i].data;
      #1 if (v[i].chk) check($sformatf("vec%0d data", i), rdata, v[i].rd);
      @(posedge clock);
      #1 cnt_check($sformatf("vec%0d", i), v[i].err, v[i].wc, v[i].ec);
    end

    // Reset arriving mid-cycle with a store pending: state clears at once, store is dropped.
    @(negedge clock);
    {we, bt, hw, sx} = 4'b1000;
    addr = 32'h10;
    wdata = 32'hCAFEF00D;
    #2 reset = 1'b1;
    #1 cnt_check("async reset", 1'b0, 32'd0, 32'd0);
    check("read during reset", rdata, 32'h01020304);
    @(posedge clock);
    #1 check("store blocked in reset", rdata, 32'h01020304);
    @(negedge clock);
    we = 1'b0;
    reset = 1'b0;
    #1 check("array kept over reset", rdata, 32'h01020304);
    addr = 32'h20;
    #1 check("array kept over reset 2", rdata, 32'h11EEABCD);
    @(posedge clock);
    #1 cnt_check("after reset", 1'b0, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
